// File: rtl/fp_add_if.sv
// fp_add_if: operand/result bundle for the pipelined Fp adder.
interface fp_add_if #(parameter int WIDTH = 255);
  logic valid_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic valid_out;
  logic [WIDTH-1:0] D;
  modport master (output valid_in, A, B, input valid_out, D);
  modport slave (input valid_in, A, B, output valid_out, D);
endinterface

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: pipelined (A + B) mod P, one limb of carry then one limb of borrow per stage.
module fp_add_pipe #(
  parameter int WIDTH = 255,
  parameter logic [WIDTH-1:0] P = 255'h4fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff,
  parameter int LIMB = 64
) (
  input logic clk,
  input logic rst,
  fp_add_if.slave io
);
  localparam int NLIMB = (WIDTH + LIMB) / LIMB;
  localparam int LATENCY_ADD = 2 * NLIMB + 1;
  localparam int W2 = NLIMB * LIMB;
  localparam logic [W2-1:0] PX = W2'(P);
  logic [W2-1:0] a_q [NLIMB];
  logic [W2-1:0] b_q [NLIMB];
  logic [W2-1:0] s_q [NLIMB];
  logic c_q [NLIMB];
  logic [W2-1:0] sp_q [NLIMB];
  logic [W2-1:0] t_q [NLIMB];
  logic w_q [NLIMB];
  logic [LATENCY_ADD-1:0] v_q;
  logic [WIDTH-1:0] d_q;
  logic [LIMB:0] sum_n [NLIMB];
  logic [LIMB:0] dif_n [NLIMB];
  logic [W2-1:0] a_x;
  logic [W2-1:0] b_x;
  assign a_x = W2'(io.A);
  assign b_x = W2'(io.B);
  // limb i of S and T resolved in its own stage; the msb of each limb result is the carry/borrow out
  always_comb begin
    sum_n[0] = {1'b0, a_x[LIMB-1:0]} + {1'b0, b_x[LIMB-1:0]};
    for (int i = 1; i < NLIMB; i++)
      sum_n[i] = {1'b0, a_q[i-1][i*LIMB +: LIMB]} + {1'b0, b_q[i-1][i*LIMB +: LIMB]} + (LIMB+1)'(c_q[i-1]);
    dif_n[0] = {1'b0, s_q[NLIMB-1][LIMB-1:0]} - {1'b0, PX[LIMB-1:0]};
    for (int j = 1; j < NLIMB; j++)
      dif_n[j] = {1'b0, sp_q[j-1][j*LIMB +: LIMB]} - {1'b0, PX[j*LIMB +: LIMB]} - (LIMB+1)'(w_q[j-1]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLIMB; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
        c_q[i] <= 1'b0;
        sp_q[i] <= '0;
        t_q[i] <= '0;
        w_q[i] <= 1'b0;
      end
      v_q <= '0;
      d_q <= '0;
    end else begin
      a_q[0] <= a_x;
      b_q[0] <= b_x;
      s_q[0] <= W2'(sum_n[0][LIMB-1:0]);
      c_q[0] <= sum_n[0][LIMB];
      for (int i = 1; i < NLIMB; i++) begin
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
        s_q[i] <= s_q[i-1];
        s_q[i][i*LIMB +: LIMB] <= sum_n[i][LIMB-1:0];
        c_q[i] <= sum_n[i][LIMB];
      end
      sp_q[0] <= s_q[NLIMB-1];
      t_q[0] <= W2'(dif_n[0][LIMB-1:0]);
      w_q[0] <= dif_n[0][LIMB];
      for (int j = 1; j < NLIMB; j++) begin
        sp_q[j] <= sp_q[j-1];
        t_q[j] <= t_q[j-1];
        t_q[j][j*LIMB +: LIMB] <= dif_n[j][LIMB-1:0];
        w_q[j] <= dif_n[j][LIMB];
      end
      v_q <= {v_q[LATENCY_ADD-2:0], io.valid_in};
      d_q <= w_q[NLIMB-1] ? sp_q[NLIMB-1][WIDTH-1:0] : t_q[NLIMB-1][WIDTH-1:0];
    end
  end
  assign io.valid_out = v_q[LATENCY_ADD-1];
  assign io.D = d_q;
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vector table plus hand-written latency, bubble and reset sequences.
module tb_fp_add_pipe;
  localparam int LAT = 9;
  localparam int N = 14;
  localparam logic [254:0] P = 255'h4fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff;
  typedef struct {
    logic v;
    logic [254:0] a;
    logic [254:0] b;
    logic [254:0] d;
  } vec_t;
  logic clk;
  logic rst;
  int total;
  int passed;
  vec_t tbl [N];
  fp_add_if #(.WIDTH(255)) io ();
  fp_add_pipe dut (.clk(clk), .rst(rst), .io(io));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [254:0] got, input logic [254:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  initial begin
    int cnt;
    total = 0;
    passed = 0;
    tbl[0] = '{1'b1, 255'd1, 255'd2, 255'd3};
    tbl[1] = '{1'b1, P - 255'd1, 255'd1, 255'd0};
    tbl[2] = '{1'b1, 255'd1 << 248, 255'd1 << 250, 255'd1};
    tbl[3] = '{1'b1, P - 255'd1, P - 255'd1, P - 255'd2};
    tbl[4] = '{1'b1, 255'd0, 255'd0, 255'd0};
    tbl[5] = '{1'b1, (255'd1 << 64) - 255'd1, 255'd1, 255'd1 << 64};
    tbl[6] = '{1'b1, P - 255'd1, 255'd2, 255'd1};
    tbl[7] = '{1'b1, 255'h258c4d3ece3e4dc8f7ce5ede51896580ff7d36722ee0d59b58b45bf8d78e1e6,
               255'h127ba0471a1f3d76c58bca5bc731dd6f91ae57c60ea264fecde8b73482c3495,
               255'h3807ed85e85d8b3fbd5a293a18bb42f0912b8e383d833a9a269d132d5a5167b};
    tbl[8] = '{1'b1, 255'h4d8965b62d5c91366ba53817a2d6b5df923ff87aec375c341aaacc2e26c320e,
               255'h37574a8b477caf2a5f274ab5c718332ee00fefa49e0c5518b2de38c133d33ea,
               255'h34e0b04174d94060cacc82cd69eee90e724fe81f8a43b14ccd8904ef5a965f9};
    tbl[9]  = '{1'b1, 255'd0, 255'd0, 255'd0};
    tbl[10] = '{1'b0, 255'd1, 255'd1, 255'd2};
    tbl[11] = '{1'b1, 255'd2, 255'd2, 255'd4};
    tbl[12] = '{1'b1, 255'd3, 255'd3, 255'd6};
    tbl[13] = '{1'b0, 255'd4, 255'd4, 255'd8};
    rst = 1'b1;
    io.valid_in = 1'b0;
    io.A = '0;
    io.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid_out", 255'(io.valid_out), 255'd0);
    check("reset D", io.D, 255'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    io.valid_in = 1'b1;
    io.A = 255'd1;
    io.B = 255'd2;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      io.valid_in = 1'b0;
      io.A = '0;
      io.B = '0;
      if (io.valid_out) break;
    end
    check("basic latency", 255'(cnt), 255'(LAT));
    check("basic D", io.D, 255'd3);
    @(posedge clk);
    #1;
    check("basic valid_out drop", 255'(io.valid_out), 255'd0);
    repeat (3) @(negedge clk);
    for (int c = 0; c < N + LAT + 2; c++) begin
      int k;
      logic ev;
      @(negedge clk);
      io.valid_in = c < N ? tbl[c].v : 1'b0;
      io.A = c < N ? tbl[c].a : '0;
      io.B = c < N ? tbl[c].b : '0;
      @(posedge clk);
      #1;
      k = c - (LAT - 1);
      ev = (k >= 0 && k < N) ? tbl[k].v : 1'b0;
      check($sformatf("stream valid_out c=%0d", c), 255'(io.valid_out), 255'(ev));
      if (ev) check($sformatf("stream D item=%0d", k), io.D, tbl[k].d);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io.valid_in = 1'b1;
      io.A = 255'(10 + i);
      io.B = 255'(10 + i);
      rst = i == 3;
    end
    @(posedge clk);
    #1;
    check("midreset valid_out", 255'(io.valid_out), 255'd0);
    check("midreset D", io.D, 255'd0);
    @(negedge clk);
    rst = 1'b0;
    io.A = 255'd100;
    io.B = 255'd200;
    @(negedge clk);
    io.valid_in = 1'b0;
    io.A = '0;
    io.B = '0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset valid_out j=%0d", j), 255'(io.valid_out), 255'(j == LAT - 1));
      if (j == LAT - 1) check("post-reset D", io.D, 255'd300);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
